tank_sprite_line_fetcher: RTL and testbench

- Per-scanline scheduler that shares one 32x32, 4-bit-index tank sprite ROM among NUM_SLOTS on-screen tanks.
- During horizontal blanking it snapshots the slot table and finds the slots that intersect the next line. It then fetches each hit slot's 32-pixel row from the shared ROM into a per-slot line buffer.
- During active video it resolves DrawX against the buffers with fixed priority and drives a palette index to the palette/colour-mapper stage.

---
 rtl/tank_sprite_line_fetcher_if.sv | 21 ++
 rtl/tank_sprite_line_fetcher.sv | 205 ++++++++++++++++++++
 tb/tb_tank_sprite_line_fetcher.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tank_sprite_line_fetcher_if.sv
// Shared sprite ROM port between the line fetcher and the ROM.
// The fetcher drives a registered address; the ROM answers one cycle later.
// There is no flow control: the ROM accepts an address every cycle.
interface tank_sprite_line_fetcher_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        rom_q;

  // Fetcher side: issues addresses, consumes pixel indices.
  modport master (
    output rom_addr,
    input  rom_q
  );

  // ROM side: consumes addresses, returns pixel indices.
  modport slave (
    input  rom_addr,
    output rom_q
  );
endinterface

// File: rtl/tank_sprite_line_fetcher.sv
// Per-scanline tank sprite scheduler. In hblank it fetches sprite rows from the shared ROM into per-slot line buffers.
// Fetch takes up to NUM_SLOTS*(SPR_W+2)+1 cycles. Pixel resolve is registered, with 1 cycle of latency from DrawX.
// There is no backpressure. A line_start that arrives while busy is dropped and reported on overrun.
module tank_sprite_line_fetcher #(
  parameter int         NUM_SLOTS = 4,
  parameter int         SPR_W     = 32,
  parameter int         SPR_H     = 32,
  parameter int         FRAME_W   = 2,
  parameter int         ADDR_W    = 12,
  parameter logic [3:0] TRANSP    = 4'h0
) (
  input  logic                          vga_clk,
  input  logic                          reset_n,
  input  logic                          line_start,
  input  logic [9:0]                    next_y,
  input  logic [NUM_SLOTS-1:0]          slot_en,
  input  logic [NUM_SLOTS*10-1:0]       slot_x,
  input  logic [NUM_SLOTS*10-1:0]       slot_y,
  input  logic [NUM_SLOTS*FRAME_W-1:0]  slot_frame,
  tank_sprite_line_fetcher_if.master    rom,
  output logic                          busy,
  output logic                          done,
  output logic                          overrun,
  input  logic [9:0]                    DrawX,
  output logic                          pix_valid,
  output logic [3:0]                    pix_index,
  output logic [$clog2(NUM_SLOTS)-1:0]  pix_slot
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int COL_W  = $clog2(SPR_W);
  localparam int ROW_W  = $clog2(SPR_H);

  localparam logic [10:0]       SPR_W_11  = 11'(SPR_W);
  localparam logic [10:0]       SPR_H_11  = 11'(SPR_H);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(SPR_W - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_SLOTS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_FETCH,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t               state;
  logic [SLOT_W-1:0]    slot;
  logic [COL_W-1:0]     col;
  logic [ROW_W-1:0]     row;
  logic [NUM_SLOTS-1:0] line_valid;

  // Snapshot of the slot table, taken when a line fetch is accepted.
  logic                 snap_en    [NUM_SLOTS];
  logic [9:0]           snap_x     [NUM_SLOTS];
  logic [9:0]           snap_y     [NUM_SLOTS];
  logic [FRAME_W-1:0]   snap_frame [NUM_SLOTS];
  logic [9:0]           snap_ny;

  // One 32-entry line buffer per slot. Contents are meaningless until line_valid is set.
  logic [3:0]           line_buf   [NUM_SLOTS][SPR_W];

  // Decode of the slot currently being checked or fetched.
  logic [FRAME_W-1:0]   cur_frame;
  logic [10:0]          dy;
  logic                 hit;

  assign cur_frame = snap_frame[slot];
  // The 11-bit difference sets its top bit when next_y is above the sprite.
  // So one unsigned compare rejects both "above" and "below".
  assign dy  = {1'b0, snap_ny} - {1'b0, snap_y[slot]};
  assign hit = snap_en[slot] && (dy < SPR_H_11);

  // Scheduler FSM: snapshot, per-slot hit check, row fetch, drain, done pulse.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      slot         <= '0;
      col          <= '0;
      row          <= '0;
      line_valid   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overrun      <= 1'b0;
      rom.rom_addr <= '0;
      snap_ny      <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        snap_en[i]    <= 1'b0;
        snap_x[i]     <= '0;
        snap_y[i]     <= '0;
        snap_frame[i] <= '0;
      end
    end else begin
      done    <= 1'b0;
      overrun <= line_start && (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (line_start) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
              snap_en[i]    <= slot_en[i];
              snap_x[i]     <= slot_x[i*10 +: 10];
              snap_y[i]     <= slot_y[i*10 +: 10];
              snap_frame[i] <= slot_frame[i*FRAME_W +: FRAME_W];
            end
            snap_ny <= next_y;
            slot    <= '0;
            busy    <= 1'b1;
            state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          // The buffer is about to be refilled or is unused for this line. Either way it is stale now.
          line_valid[slot] <= 1'b0;
          if (hit) begin
            row          <= dy[ROW_W-1:0];
            col          <= '0;
            // Present column 0 now so the ROM data trails the column counter by exactly one cycle.
            rom.rom_addr <= ADDR_W'({cur_frame, dy[ROW_W-1:0], COL_W'(0)});
            state        <= S_FETCH;
          end else if (slot == SLOT_LAST) begin
            state <= S_FINISH;
          end else begin
            slot <= slot + 1'b1;
          end
        end
        S_FETCH: begin
          if (col == COL_LAST) begin
            state <= S_DRAIN;
          end else begin
            col          <= col + 1'b1;
            rom.rom_addr <= ADDR_W'({cur_frame, row, col + 1'b1});
          end
        end
        S_DRAIN: begin
          line_valid[slot] <= 1'b1;
          if (slot == SLOT_LAST) begin
            state <= S_FINISH;
          end else begin
            slot  <= slot + 1'b1;
            state <= S_CHECK;
          end
        end
        S_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Line buffer fill: rom_q always belongs to the column issued in the previous cycle.
  always_ff @(posedge vga_clk) begin
    if (state == S_FETCH && col != '0) begin
      line_buf[slot][col - 1'b1] <= rom.rom_q;
    end else if (state == S_DRAIN) begin
      line_buf[slot][col] <= rom.rom_q;
    end
  end

  // Per-slot coverage and opacity at the current DrawX.
  logic [10:0]          dx [NUM_SLOTS];
  logic [3:0]           px [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] opaque;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    // A negative offset wraps to 11'h4xx or above, so it fails the width test. There is no left-edge wrap.
    assign dx[g]     = {1'b0, DrawX} - {1'b0, snap_x[g]};
    assign px[g]     = line_buf[g][dx[g][COL_W-1:0]];
    assign opaque[g] = line_valid[g] && (dx[g] < SPR_W_11) && (px[g] != TRANSP);
  end

  logic              win_vld;
  logic [3:0]        win_idx;
  logic [SLOT_W-1:0] win_slot;

  // Fixed priority: scan from the highest slot down so the lowest opaque slot overwrites the others.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    win_slot = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (opaque[i]) begin
        win_vld  = 1'b1;
        win_idx  = px[i];
        win_slot = SLOT_W'(i);
      end
    end
  end

  // Register the winning pixel for the colour mapper.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_valid <= 1'b0;
      pix_index <= '0;
      pix_slot  <= '0;
    end else begin
      pix_valid <= win_vld;
      pix_index <= win_idx;
      pix_slot  <= win_slot;
    end
  end

endmodule

// File: tb/tb_tank_sprite_line_fetcher.sv
// Directed bench for tank_sprite_line_fetcher. It uses a ROM model that returns rom_addr[3:0] one cycle later.
// Timing and pixel expectations are hand-derived constants or simple formulas on the stimulus.
// Each scenario task does its own inline checks. A single summary line is printed at the end.
module tb_tank_sprite_line_fetcher;

  logic        vga_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        line_start = 1'b0;
  logic [9:0]  next_y = '0;
  logic [3:0]  slot_en = '0;
  logic [39:0] slot_x = '0;
  logic [39:0] slot_y = '0;
  logic [7:0]  slot_frame = '0;
  logic [9:0]  DrawX = '0;
  logic        busy, done, overrun, pix_valid;
  logic [3:0]  pix_index;
  logic [1:0]  pix_slot;

  int checks = 0;
  int errors = 0;

  // Results of the most recent run_line.
  logic [11:0] trace[$];
  int          done_cyc;
  int          n_busy;
  int          ovr_cnt;
  logic        busy_at_done;

  tank_sprite_line_fetcher_if #(.ADDR_W(12)) rif ();

  tank_sprite_line_fetcher dut (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .line_start (line_start),
    .next_y     (next_y),
    .slot_en    (slot_en),
    .slot_x     (slot_x),
    .slot_y     (slot_y),
    .slot_frame (slot_frame),
    .rom        (rif.master),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun),
    .DrawX      (DrawX),
    .pix_valid  (pix_valid),
    .pix_index  (pix_index),
    .pix_slot   (pix_slot)
  );

  always #5 vga_clk = ~vga_clk;

  // Synchronous ROM: data is the low nibble of the address, one cycle late.
  always @(posedge vga_clk) rif.rom_q <= rif.rom_addr[3:0];

  // Stimulus: pulse line_start for ny, then sample each cycle until done (bounded).
  // If again_at > 0, a second line_start is pulsed on that cycle. The slot table and next_y are disturbed at the same time.
  task automatic run_line(input logic [9:0] ny, input int again_at);
    trace.delete();
    done_cyc = 0;
    n_busy = 0;
    ovr_cnt = 0;
    busy_at_done = 1'b1;
    @(negedge vga_clk);
    next_y = ny;
    line_start = 1'b1;
    @(negedge vga_clk);
    line_start = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      if (overrun === 1'b1) ovr_cnt++;
      if (done === 1'b1) begin
        done_cyc = cyc;
        busy_at_done = busy;
        break;
      end
      if (busy === 1'b1) n_busy++;
      trace.push_back(rif.rom_addr);
      if (cyc == again_at) begin
        line_start = 1'b1;
        next_y = ny + 10'd7;
        slot_x[9:0] = 10'd300;
      end
      @(negedge vga_clk);
      line_start = 1'b0;
    end
  endtask

  task automatic test_reset;
    for (int k = 0; k < 5; k++) begin
      @(negedge vga_clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || pix_valid !== 1'b0 || overrun !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d busy=%b done=%b pix_valid=%b overrun=%b want all 0", k, busy, done, pix_valid, overrun);
      end
    end
    checks++;
    if (rif.rom_addr !== 12'h000) begin
      errors++;
      $display("FAIL reset_rom_addr got %h want 000", rif.rom_addr);
    end
    checks++;
    if (pix_index !== 4'h0 || pix_slot !== 2'd0) begin
      errors++;
      $display("FAIL reset_pix got idx=%h slot=%0d want 0/0", pix_index, pix_slot);
    end
  endtask

  task automatic test_single_fetch;
    slot_en = 4'b0001;
    slot_x[9:0] = 10'd100;
    slot_y[9:0] = 10'd50;
    slot_frame[1:0] = 2'd2;
    run_line(10'd53, 0);
    checks++;
    if (done_cyc !== 39 || n_busy !== 38 || busy_at_done !== 1'b0) begin
      errors++;
      $display("FAIL single_done_timing got done_cyc=%0d busy_cycles=%0d busy_at_done=%b want 39/38/0", done_cyc, n_busy, busy_at_done);
    end
    for (int c = 0; c < 32; c++) begin
      checks++;
      if (trace.size() < 34 || trace[1+c] !== 12'(12'h860 + c)) begin
        errors++;
        $display("FAIL single_rom_addr col %0d got %h want %h", c, (trace.size() > 1 + c) ? trace[1+c] : 12'hxxx, 12'(12'h860 + c));
      end
    end
    @(negedge vga_clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL single_done_pulse got done=%b one cycle later want 0", done);
    end
    for (int d = 99; d <= 132; d++) begin
      logic       ev;
      logic [3:0] ei;
      ev = (d >= 100) && (d <= 131) && (((d - 100) % 16) != 0);
      ei = ev ? 4'((d - 100) % 16) : 4'h0;
      DrawX = 10'(d);
      @(negedge vga_clk);
      checks++;
      if (pix_valid !== ev || pix_index !== ei || pix_slot !== 2'd0) begin
        errors++;
        $display("FAIL single_pix DrawX=%0d got v=%b i=%h s=%0d want v=%b i=%h s=0", d, pix_valid, pix_index, pix_slot, ev, ei);
      end
    end
  endtask

  task automatic test_overlap;
    int         dxv [8];
    logic       ev  [8];
    logic [3:0] ei  [8];
    logic [1:0] es  [8];
    dxv = '{215, 216, 226, 232, 200, 210, 241, 242};
    ev  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    ei  = '{4'hF, 4'h6, 4'hA, 4'h6, 4'h0, 4'hA, 4'hF, 4'h0};
    es  = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0};
    slot_en = 4'b0011;
    slot_x = '0;
    slot_y = '0;
    slot_frame = '0;
    slot_x[9:0] = 10'd200;
    slot_x[19:10] = 10'd210;
    slot_frame[3:2] = 2'd1;
    run_line(10'd0, 0);
    checks++;
    if (done_cyc !== 72) begin
      errors++;
      $display("FAIL overlap_done_timing got done_cyc=%0d want 72", done_cyc);
    end
    checks++;
    if (trace.size() < 68 || trace[35] !== 12'h400 || trace[66] !== 12'h41F) begin
      errors++;
      $display("FAIL overlap_slot1_addr got %h..%h want 400..41F", (trace.size() > 35) ? trace[35] : 12'hxxx, (trace.size() > 66) ? trace[66] : 12'hxxx);
    end
    for (int k = 0; k < 8; k++) begin
      DrawX = 10'(dxv[k]);
      @(negedge vga_clk);
      checks++;
      if (pix_valid !== ev[k] || pix_index !== ei[k] || pix_slot !== es[k]) begin
        errors++;
        $display("FAIL overlap_pix DrawX=%0d got v=%b i=%h s=%0d want v=%b i=%h s=%0d", dxv[k], pix_valid, pix_index, pix_slot, ev[k], ei[k], es[k]);
      end
    end
  endtask

  task automatic test_boundary;
    logic [9:0] miss_y [2];
    miss_y = '{10'd49, 10'd82};
    slot_en = 4'b0001;
    slot_x = '0;
    slot_y = '0;
    slot_frame = '0;
    slot_x[9:0] = 10'd100;
    slot_y[9:0] = 10'd50;
    slot_frame[1:0] = 2'd2;
    for (int m = 0; m < 2; m++) begin
      run_line(miss_y[m], 0);
      checks++;
      if (done_cyc !== 6 || n_busy !== 5) begin
        errors++;
        $display("FAIL boundary_miss_timing ny=%0d got done_cyc=%0d busy_cycles=%0d want 6/5", miss_y[m], done_cyc, n_busy);
      end
      checks++;
      if (trace.size() < 5 || trace[4] !== 12'h41F) begin
        errors++;
        $display("FAIL boundary_miss_no_fetch ny=%0d got rom_addr=%h want 41F", miss_y[m], (trace.size() > 4) ? trace[4] : 12'hxxx);
      end
      DrawX = 10'd110;
      @(negedge vga_clk);
      checks++;
      if (pix_valid !== 1'b0) begin
        errors++;
        $display("FAIL boundary_miss_pix ny=%0d got pix_valid=%b want 0", miss_y[m], pix_valid);
      end
    end
    run_line(10'd81, 0);
    checks++;
    if (done_cyc !== 39 || trace.size() < 34 || trace[1] !== 12'hBE0 || trace[32] !== 12'hBFF) begin
      errors++;
      $display("FAIL boundary_row31 got done_cyc=%0d first=%h last=%h want 39 BE0 BFF", done_cyc, (trace.size() > 1) ? trace[1] : 12'hxxx, (trace.size() > 32) ? trace[32] : 12'hxxx);
    end
    DrawX = 10'd105;
    @(negedge vga_clk);
    checks++;
    if (pix_valid !== 1'b1 || pix_index !== 4'h5) begin
      errors++;
      $display("FAIL boundary_row31_pix got v=%b i=%h want 1/5", pix_valid, pix_index);
    end
  endtask

  task automatic test_overrun;
    slot_en = 4'b0001;
    slot_x = '0;
    slot_y = '0;
    slot_frame = '0;
    slot_x[9:0] = 10'd100;
    slot_y[9:0] = 10'd50;
    slot_frame[1:0] = 2'd2;
    run_line(10'd53, 10);
    checks++;
    if (ovr_cnt !== 1) begin
      errors++;
      $display("FAIL overrun_count got %0d pulses want 1", ovr_cnt);
    end
    checks++;
    if (done_cyc !== 39 || trace.size() < 34 || trace[1] !== 12'h860 || trace[32] !== 12'h87F) begin
      errors++;
      $display("FAIL overrun_fetch got done_cyc=%0d first=%h last=%h want 39 860 87F", done_cyc, (trace.size() > 1) ? trace[1] : 12'hxxx, (trace.size() > 32) ? trace[32] : 12'hxxx);
    end
    @(negedge vga_clk);
    @(negedge vga_clk);
    checks++;
    if (busy !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_idle_after got busy=%b overrun=%b want 0/0", busy, overrun);
    end
    // slot_x input now says 300; the snapshot still places the sprite at 100.
    for (int d = 100; d <= 131; d += 5) begin
      logic       ev;
      logic [3:0] ei;
      ev = (((d - 100) % 16) != 0);
      ei = ev ? 4'((d - 100) % 16) : 4'h0;
      DrawX = 10'(d);
      @(negedge vga_clk);
      checks++;
      if (pix_valid !== ev || pix_index !== ei) begin
        errors++;
        $display("FAIL overrun_snapshot_pix DrawX=%0d got v=%b i=%h want v=%b i=%h", d, pix_valid, pix_index, ev, ei);
      end
    end
    slot_x[9:0] = 10'd100;
  endtask

  task automatic test_reset_mid;
    @(negedge vga_clk);
    next_y = 10'd53;
    line_start = 1'b1;
    @(negedge vga_clk);
    line_start = 1'b0;
    repeat (10) @(negedge vga_clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rif.rom_addr !== 12'h000 || pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async got busy=%b done=%b rom_addr=%h pix_valid=%b want 0/0/000/0", busy, done, rif.rom_addr, pix_valid);
    end
    repeat (2) @(negedge vga_clk);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge vga_clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_idle cyc %0d got busy=%b done=%b want 0/0", k, busy, done);
      end
    end
    for (int d = 95; d <= 135; d += 4) begin
      DrawX = 10'(d);
      @(negedge vga_clk);
      checks++;
      if (pix_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_pix DrawX=%0d got pix_valid=%b want 0", d, pix_valid);
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge vga_clk);
    reset_n = 1'b1;
    test_reset();
    test_single_fetch();
    test_overlap();
    test_boundary();
    test_overrun();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
